onchip_mem_stream_reader: RTL and testbench

Avalon-MM read master that sits directly in front of the 87,500 × 32-bit single-port on-chip RAM. It streams a programmed run of consecutive words out of the RAM onto a valid/ready stream interface for downstream consumers such as the frame/sprite pipeline. It absorbs the RAM's 1-cycle read latency and any downstream backpressure with a small internal FIFO, and sustains 1 word/cycle when the consumer never stalls.

---
 rtl/onchip_mem_stream_reader.sv | 120 ++++++++++++
 tb/tb_onchip_mem_stream_reader.sv | 370 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/onchip_mem_stream_reader.sv
// Avalon-MM read master streaming a run of consecutive on-chip RAM words onto a
// valid/ready interface, with a small FWFT FIFO absorbing read latency and backpressure.
module onchip_mem_stream_reader #(
  parameter int MEM_WORDS  = 87500,
  parameter int ADDR_W     = 17,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] length,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [3:0]        mem_byteenable,
  output logic              mem_clken,
  input  logic [31:0]       mem_readdata,
  output logic [31:0]       st_data,
  output logic              st_valid,
  input  logic              st_ready,
  output logic              st_last
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MEM_WORDS - 1);
  localparam logic [CNT_W:0]    DEPTH_OCC = (CNT_W + 1)'(FIFO_DEPTH);

  logic [1:0]        state;
  logic [ADDR_W-1:0] remaining;
  logic              inflight;
  logic              inflight_last;
  logic [32:0]       fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [CNT_W-1:0]  count;
  logic [CNT_W:0]    occupancy;
  logic              pop;
  logic              issue;
  logic              last_issue;

  // A read is only issued if its data is guaranteed a FIFO slot on arrival.
  assign pop        = st_valid & st_ready;
  assign occupancy  = {1'b0, count} + (CNT_W + 1)'(inflight) - (CNT_W + 1)'(pop);
  assign issue      = (state == S_RUN) && (occupancy < DEPTH_OCC);
  assign last_issue = issue && (remaining == ADDR_W'(1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
    end else begin
      case (state)
        S_IDLE:  if (start) state <= (length == '0) ? S_DONE : S_RUN;
        S_RUN:   if (last_issue) state <= S_DRAIN;
        S_DRAIN: if (pop && st_last) state <= S_DONE;
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_address   <= '0;
      remaining     <= '0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
    end else begin
      inflight      <= issue;
      inflight_last <= last_issue;
      if (state == S_IDLE && start && length != '0) begin
        mem_address <= base_addr;
        remaining   <= length;
      end else if (issue) begin
        mem_address <= (mem_address == LAST_ADDR) ? '0 : mem_address + ADDR_W'(1);
        remaining   <= remaining - ADDR_W'(1);
      end
    end
  end

  // Pointers wrap naturally because the depth is a power of two.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (inflight) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)      rd_ptr <= rd_ptr + PTR_W'(1);
      case ({inflight, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (inflight) fifo_mem[wr_ptr] <= {inflight_last, mem_readdata};
  end

  assign st_valid       = (count != '0);
  assign st_data        = st_valid ? fifo_mem[rd_ptr][31:0] : 32'h0;
  assign st_last        = st_valid & fifo_mem[rd_ptr][32];
  assign busy           = (state == S_RUN) || (state == S_DRAIN);
  assign done           = (state == S_DONE);
  assign mem_chipselect = issue;
  assign mem_write      = 1'b0;
  assign mem_byteenable = 4'hF;
  assign mem_clken      = 1'b1;

endmodule

// File: tb/tb_onchip_mem_stream_reader.sv
// Directed bench for onchip_mem_stream_reader: RAM model returns A000_0000 + address
// one cycle after chipselect; a negedge monitor records issues, beats and done pulses.
module tb_onchip_mem_stream_reader;

  localparam int ADDR_W     = 17;
  localparam int MEM_WORDS  = 87500;
  localparam int FIFO_DEPTH = 4;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] base_addr = '0;
  logic [ADDR_W-1:0] length = '0;
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] mem_address;
  logic              mem_chipselect;
  logic              mem_write;
  logic [3:0]        mem_byteenable;
  logic              mem_clken;
  logic [31:0]       mem_readdata = 32'h0;
  logic [31:0]       st_data;
  logic              st_valid;
  logic              st_ready = 1'b0;
  logic              st_last;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  int                cs_count = 0;
  int                busy_cnt = 0;
  int                occ_model = 0;
  bit                overflow = 1'b0;
  logic [ADDR_W-1:0] addr_q[$];
  logic [31:0]       beat_q[$];
  bit                last_q[$];
  int                beat_cyc_q[$];
  int                done_q[$];

  onchip_mem_stream_reader #(
    .MEM_WORDS(MEM_WORDS), .ADDR_W(ADDR_W), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .base_addr(base_addr), .length(length),
    .busy(busy), .done(done), .mem_address(mem_address), .mem_chipselect(mem_chipselect),
    .mem_write(mem_write), .mem_byteenable(mem_byteenable), .mem_clken(mem_clken),
    .mem_readdata(mem_readdata), .st_data(st_data), .st_valid(st_valid),
    .st_ready(st_ready), .st_last(st_last)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Single-port RAM with 1-cycle read latency, preloaded with word i = A000_0000 + i.
  always @(posedge clk) if (mem_chipselect) mem_readdata <= 32'hA000_0000 + 32'(mem_address);

  initial begin
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        occ_model = 0;
      end else begin
        if (occ_model > FIFO_DEPTH) overflow = 1'b1;
        if (mem_chipselect) begin
          cs_count++;
          addr_q.push_back(mem_address);
          occ_model++;
        end
        if (st_valid && st_ready) begin
          beat_q.push_back(st_data);
          last_q.push_back(st_last);
          beat_cyc_q.push_back(cyc);
          occ_model--;
        end
        if (done) done_q.push_back(cyc);
        if (busy) busy_cnt++;
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic pulse_start(input logic [ADDR_W-1:0] b, input logic [ADDR_W-1:0] l,
                             output int c0);
    @(posedge clk); #1;
    start = 1'b1; base_addr = b; length = l; c0 = cyc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int d0, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (done_q.size() > d0) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done got %b want 0", done); end
    checks++; if (st_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid got %b want 0", st_valid); end
    checks++; if (mem_chipselect !== 1'b0) begin errors++; $display("[TB] FAIL reset_cs got %b want 0", mem_chipselect); end
    checks++; if (mem_address !== '0) begin errors++; $display("[TB] FAIL reset_addr got %0d want 0", mem_address); end
    checks++;
    if (mem_write !== 1'b0 || mem_byteenable !== 4'hF || mem_clken !== 1'b1) begin
      errors++;
      $display("[TB] FAIL tie_offs got write=%b be=%h clken=%b want 0 f 1", mem_write, mem_byteenable, mem_clken);
    end
    reset_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_basic(input string name);
    int  b0, cs0, d0, c0;
    bit  ok;
    st_ready = 1'b1;
    b0 = beat_q.size(); cs0 = cs_count; d0 = done_q.size();
    pulse_start(17'd16, 17'd8, c0);
    checks++;
    if (busy !== 1'b1 || mem_chipselect !== 1'b1 || mem_address !== 17'd16) begin
      errors++;
      $display("[TB] FAIL %s_cycle1 got busy=%b cs=%b addr=%0d want 1 1 16", name, busy, mem_chipselect, mem_address);
    end
    wait_done(d0, 60, ok);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL %s_timeout got no done want done", name); end
    checks++;
    if (beat_q.size() - b0 != 8) begin
      errors++; $display("[TB] FAIL %s_beats got %0d want 8", name, beat_q.size() - b0);
    end
    for (int i = 0; i < 8 && b0 + i < beat_q.size(); i++) begin
      checks++;
      if (beat_q[b0+i] !== 32'hA000_0010 + 32'(i) || last_q[b0+i] !== (i == 7)) begin
        errors++;
        $display("[TB] FAIL %s_beat%0d got %h last=%b want %h last=%b", name, i,
                 beat_q[b0+i], last_q[b0+i], 32'hA000_0010 + 32'(i), (i == 7));
      end
    end
    if (beat_q.size() - b0 == 8) begin
      checks++;
      if (beat_cyc_q[b0] - c0 != 3 || beat_cyc_q[b0+7] - c0 != 10) begin
        errors++;
        $display("[TB] FAIL %s_beat_timing got first=%0d last=%0d want 3 10", name,
                 beat_cyc_q[b0] - c0, beat_cyc_q[b0+7] - c0);
      end
    end
    if (ok) begin
      checks++;
      if (done_q[d0] - c0 != 11) begin
        errors++; $display("[TB] FAIL %s_done_cycle got %0d want 11", name, done_q[d0] - c0);
      end
    end
    checks++;
    if (cs_count - cs0 != 8) begin
      errors++; $display("[TB] FAIL %s_chipselects got %0d want 8", name, cs_count - cs0);
    end
  endtask

  task automatic test_wrap();
    int                b0, a0, d0, c0;
    bit                ok;
    logic [ADDR_W-1:0] exp_addr [4];
    exp_addr[0] = 17'd87498; exp_addr[1] = 17'd87499; exp_addr[2] = 17'd0; exp_addr[3] = 17'd1;
    st_ready = 1'b1;
    b0 = beat_q.size(); a0 = addr_q.size(); d0 = done_q.size();
    pulse_start(17'd87498, 17'd4, c0);
    wait_done(d0, 40, ok);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL wrap_timeout got no done want done"); end
    checks++;
    if (addr_q.size() - a0 != 4 || beat_q.size() - b0 != 4) begin
      errors++;
      $display("[TB] FAIL wrap_counts got addrs=%0d beats=%0d want 4 4", addr_q.size() - a0, beat_q.size() - b0);
    end
    for (int i = 0; i < 4 && a0 + i < addr_q.size() && b0 + i < beat_q.size(); i++) begin
      checks++;
      if (addr_q[a0+i] !== exp_addr[i] || beat_q[b0+i] !== 32'hA000_0000 + 32'(exp_addr[i])) begin
        errors++;
        $display("[TB] FAIL wrap_word%0d got addr=%0d data=%h want addr=%0d data=%h", i,
                 addr_q[a0+i], beat_q[b0+i], exp_addr[i], 32'hA000_0000 + 32'(exp_addr[i]));
      end
    end
  endtask

  task automatic test_backpressure();
    int  b0, cs0, d0, c0;
    bit  ok;
    // Random 50% backpressure over a 20-word run.
    b0 = beat_q.size(); cs0 = cs_count; d0 = done_q.size();
    st_ready = 1'b0;
    pulse_start(17'd200, 17'd20, c0);
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (done_q.size() > d0) begin ok = 1'b1; break; end
      @(posedge clk); #1;
      st_ready = 1'($urandom_range(0, 1));
    end
    st_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (!ok) begin errors++; $display("[TB] FAIL bp_rand_timeout got no done want done"); end
    checks++;
    if (beat_q.size() - b0 != 20 || cs_count - cs0 != 20) begin
      errors++;
      $display("[TB] FAIL bp_rand_counts got beats=%0d cs=%0d want 20 20", beat_q.size() - b0, cs_count - cs0);
    end
    for (int i = 0; i < 20 && b0 + i < beat_q.size(); i++) begin
      checks++;
      if (beat_q[b0+i] !== 32'hA000_00C8 + 32'(i) || last_q[b0+i] !== (i == 19)) begin
        errors++;
        $display("[TB] FAIL bp_rand_beat%0d got %h last=%b want %h last=%b", i,
                 beat_q[b0+i], last_q[b0+i], 32'hA000_00C8 + 32'(i), (i == 19));
      end
    end
    checks++; if (overflow !== 1'b0) begin errors++; $display("[TB] FAIL bp_occupancy got overflow want <= %0d", FIFO_DEPTH); end

    // Consumer stalled for 10 cycles: exactly FIFO_DEPTH reads, then silence.
    b0 = beat_q.size(); cs0 = cs_count; d0 = done_q.size();
    st_ready = 1'b0;
    pulse_start(17'd300, 17'd20, c0);
    repeat (9) @(posedge clk);
    #1;
    checks++;
    if (cs_count - cs0 != FIFO_DEPTH || mem_chipselect !== 1'b0) begin
      errors++;
      $display("[TB] FAIL bp_stall_cs got issued=%0d cs=%b want %0d 0", cs_count - cs0, mem_chipselect, FIFO_DEPTH);
    end
    checks++;
    if (st_valid !== 1'b1 || st_data !== 32'hA000_012C) begin
      errors++; $display("[TB] FAIL bp_stall_head got valid=%b data=%h want 1 a000012c", st_valid, st_data);
    end
    st_ready = 1'b1;
    wait_done(d0, 60, ok);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL bp_stall_timeout got no done want done"); end
    checks++;
    if (beat_q.size() - b0 != 20) begin
      errors++; $display("[TB] FAIL bp_stall_beats got %0d want 20", beat_q.size() - b0);
    end
    for (int i = 0; i < 20 && b0 + i < beat_q.size(); i++) begin
      checks++;
      if (beat_q[b0+i] !== 32'hA000_012C + 32'(i)) begin
        errors++;
        $display("[TB] FAIL bp_stall_beat%0d got %h want %h", i, beat_q[b0+i], 32'hA000_012C + 32'(i));
      end
    end
  endtask

  task automatic test_zero_length();
    int  b0, cs0, d0, c0, busy0;
    st_ready = 1'b1;
    b0 = beat_q.size(); cs0 = cs_count; d0 = done_q.size(); busy0 = busy_cnt;
    pulse_start(17'd5, 17'd0, c0);
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (done_q.size() - d0 != 1) begin
      errors++; $display("[TB] FAIL zero_done_count got %0d want 1", done_q.size() - d0);
    end else begin
      checks++;
      if (done_q[d0] - c0 != 1) begin
        errors++; $display("[TB] FAIL zero_done_cycle got %0d want 1", done_q[d0] - c0);
      end
    end
    checks++;
    if (cs_count - cs0 != 0 || busy_cnt - busy0 != 0 || beat_q.size() - b0 != 0) begin
      errors++;
      $display("[TB] FAIL zero_activity got cs=%0d busy=%0d beats=%0d want 0 0 0",
               cs_count - cs0, busy_cnt - busy0, beat_q.size() - b0);
    end
  endtask

  task automatic test_ignored_start();
    int  b0, cs0, d0, c0;
    bit  ok;
    st_ready = 1'b1;
    b0 = beat_q.size(); cs0 = cs_count; d0 = done_q.size();
    pulse_start(17'd16, 17'd8, c0);
    repeat (2) @(posedge clk);
    #1;
    start = 1'b1; base_addr = 17'd500; length = 17'd3;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(d0, 60, ok);
    repeat (10) @(posedge clk);
    #1;
    checks++; if (!ok) begin errors++; $display("[TB] FAIL ign_timeout got no done want done"); end
    checks++;
    if (done_q.size() - d0 != 1 || beat_q.size() - b0 != 8 || cs_count - cs0 != 8) begin
      errors++;
      $display("[TB] FAIL ign_counts got done=%0d beats=%0d cs=%0d want 1 8 8",
               done_q.size() - d0, beat_q.size() - b0, cs_count - cs0);
    end
    for (int i = 0; i < 8 && b0 + i < beat_q.size(); i++) begin
      checks++;
      if (beat_q[b0+i] !== 32'hA000_0010 + 32'(i) || last_q[b0+i] !== (i == 7)) begin
        errors++;
        $display("[TB] FAIL ign_beat%0d got %h last=%b want %h last=%b", i,
                 beat_q[b0+i], last_q[b0+i], 32'hA000_0010 + 32'(i), (i == 7));
      end
    end
    if (ok) begin
      checks++;
      if (done_q[d0] - c0 != 11) begin
        errors++; $display("[TB] FAIL ign_done_cycle got %0d want 11", done_q[d0] - c0);
      end
    end
  endtask

  task automatic test_reset_mid_run();
    int  b0, d0, c0;
    bit  ok;
    st_ready = 1'b1;
    b0 = beat_q.size(); d0 = done_q.size();
    pulse_start(17'd40, 17'd10, c0);
    ok = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (beat_q.size() - b0 >= 3) begin ok = 1'b1; break; end
      @(posedge clk); #1;
    end
    checks++; if (!ok) begin errors++; $display("[TB] FAIL rst_mid_timeout got <3 beats want 3"); end
    reset_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || st_valid !== 1'b0 || st_last !== 1'b0) begin
      errors++;
      $display("[TB] FAIL rst_mid_status got busy=%b done=%b valid=%b last=%b want 0 0 0 0",
               busy, done, st_valid, st_last);
    end
    checks++;
    if (mem_chipselect !== 1'b0 || mem_address !== '0 || st_data !== 32'h0) begin
      errors++;
      $display("[TB] FAIL rst_mid_mem got cs=%b addr=%0d data=%h want 0 0 0", mem_chipselect, mem_address, st_data);
    end
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (done_q.size() != d0) begin
      errors++; $display("[TB] FAIL rst_mid_no_done got %0d done pulses want 0", done_q.size() - d0);
    end
    test_basic("after_reset");
  endtask

  initial begin
    test_reset();
    test_basic("basic");
    test_wrap();
    test_backpressure();
    test_zero_length();
    test_ignored_start();
    test_reset_mid_run();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
